// File: rtl/iob_soc_versat_ddr_init_seq.sv
// DDR bring-up sequencer: pulses DDR sys_rst, waits for calibration, then releases the SoC reset.
// Define IOB_SOC_VERSAT_DDR_INIT_RETRY_EN to retry timed-out calibration up to MAX_RETRIES times.
module iob_soc_versat_ddr_init_seq #(
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned CAL_TIMEOUT = 2000000,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned CNT_W       = 24,
    localparam int unsigned RETRY_W    = 4
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               calib_done_i,
    input  logic               start_i,
    output logic               ddr_sys_rst_o,
    output logic               soc_arst_o,
    output logic               ready_o,
    output logic               error_o,
    output logic               lost_o,
    output logic [RETRY_W-1:0] retries_o,
    output logic [2:0]         state_o
);

`ifdef IOB_SOC_VERSAT_DDR_INIT_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CAL_LAST    = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        DDR_RST  = 3'd0,
        WAIT_CAL = 3'd1,
        HOLD     = 3'd2,
        RUN      = 3'd3,
        FAIL     = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [RETRY_W-1:0]   retries_d;
    logic                 lost_d;
    logic                 cal_meta;
    logic                 cal_s;
    logic                 can_retry;

    assign state_o   = state_q;
    assign can_retry = RETRY_EN && (retries_o < RETRY_LIMIT);

    // Next-state decision; start_i overrides every other transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        retries_d = retries_o;
        lost_d    = 1'b0;
        if (start_i) begin
            state_d   = DDR_RST;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                DDR_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_CAL;
                        cnt_d   = '0;
                    end
                end
                WAIT_CAL: begin
                    if (cal_s) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == CAL_LAST) begin
                        cnt_d = '0;
                        if (can_retry) begin
                            state_d   = DDR_RST;
                            retries_d = retries_o + RETRY_W'(1);
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end
                HOLD: begin
                    if (!cal_s) begin
                        state_d = DDR_RST;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!cal_s) begin
                        state_d   = DDR_RST;
                        retries_d = '0;
                        lost_d    = 1'b1;
                    end
                end
                FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = DDR_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, synchroniser and registered outputs decoded from the next state
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cal_meta      <= 1'b0;
            cal_s         <= 1'b0;
            state_q       <= DDR_RST;
            cnt_q         <= '0;
            retries_o     <= '0;
            lost_o        <= 1'b0;
            ddr_sys_rst_o <= 1'b1;
            soc_arst_o    <= 1'b1;
            ready_o       <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            cal_meta      <= calib_done_i;
            cal_s         <= cal_meta;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retries_o     <= retries_d;
            lost_o        <= lost_d;
            ddr_sys_rst_o <= (state_d == DDR_RST);
            soc_arst_o    <= (state_d != RUN);
            ready_o       <= (state_d == RUN);
            error_o       <= (state_d == FAIL);
        end
    end

endmodule

// File: tb/tb_iob_soc_versat_ddr_init_seq.sv
// Self-checking bench: phase/elapsed-time reference model compared every cycle, plus directed scenarios.
module tb_iob_soc_versat_ddr_init_seq;

    localparam int unsigned RST_CYCLES  = 4;
    localparam int unsigned CAL_TIMEOUT = 100;
    localparam int unsigned HOLD_CYCLES = 10;
    localparam int unsigned MAX_RETRIES = 3;
    localparam int unsigned CNT_W       = 24;
`ifdef IOB_SOC_VERSAT_DDR_INIT_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arstn;
    logic       calib;
    logic       start;
    logic       ddr_sys_rst;
    logic       soc_arst;
    logic       ready;
    logic       error;
    logic       lost;
    logic [3:0] retries;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    iob_soc_versat_ddr_init_seq #(
        .RST_CYCLES (RST_CYCLES),
        .CAL_TIMEOUT(CAL_TIMEOUT),
        .HOLD_CYCLES(HOLD_CYCLES),
        .MAX_RETRIES(MAX_RETRIES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .calib_done_i (calib),
        .start_i      (start),
        .ddr_sys_rst_o(ddr_sys_rst),
        .soc_arst_o   (soc_arst),
        .ready_o      (ready),
        .error_o      (error),
        .lost_o       (lost),
        .retries_o    (retries),
        .state_o      (state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: phase number plus the edge index at which the phase was entered
    int m_ph = 0, m_ret = 0, cyc = 0, m_enter = 0, m_k = 0, m_nph = 0;
    bit m_lost = 0, m_s1 = 0, m_s2 = 0, m_cal = 0, m_restart = 0;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_ph = 0; m_ret = 0; m_lost = 0; m_s1 = 0; m_s2 = 0; m_enter = cyc;
        end else begin
            cyc++;
            m_cal = m_s2; m_s2 = m_s1; m_s1 = calib;
            m_k = cyc - m_enter;
            m_lost = 0; m_restart = 0; m_nph = m_ph;
            if (start) begin
                m_nph = 0; m_ret = 0; m_restart = 1;
            end else begin
                case (m_ph)
                    0: if (m_k >= int'(RST_CYCLES)) m_nph = 1;
                    1: begin
                        if (m_cal) m_nph = 2;
                        else if (m_k >= int'(CAL_TIMEOUT)) begin
                            if (RETRY_EN && m_ret < int'(MAX_RETRIES)) begin m_ret++; m_nph = 0; end
                            else m_nph = 4;
                        end
                    end
                    2: begin
                        if (!m_cal) m_nph = 0;
                        else if (m_k >= int'(HOLD_CYCLES)) m_nph = 3;
                    end
                    3: if (!m_cal) begin m_nph = 0; m_lost = 1; m_ret = 0; end
                    default: ;
                endcase
            end
            if (m_restart || m_nph != m_ph) begin m_ph = m_nph; m_enter = cyc; end
        end
    end

    // Cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en)
            check("cycle {state,ddr,soc,ready,err,lost,retries}",
                  32'({state, ddr_sys_rst, soc_arst, ready, error, lost, retries}),
                  32'({3'(m_ph), m_ph == 0, m_ph != 3, m_ph == 3, m_ph == 4, m_lost, 4'(m_ret)}));
    end

    initial begin
        int pw, n, falls;
        bit prev;
        arstn = 1'b0; calib = 1'b0; start = 1'b0;
        tick(3);
        chk_en = 1'b1;
        check("reset state", 32'(state), 0);
        check("reset ddr_sys_rst", 32'(ddr_sys_rst), 1);
        check("reset soc_arst", 32'(soc_arst), 1);
        check("reset ready/error/lost", 32'({ready, error, lost}), 0);
        check("reset retries", 32'(retries), 0);
        arstn = 1'b1;

        // Normal bring-up
        pw = 0;
        for (int i = 0; i < 50 && ddr_sys_rst; i++) begin pw++; tick(1); end
        check("first ddr pulse width", 32'(pw), 4);
        tick(50);
        calib = 1'b1;
        n = 0;
        while (soc_arst && n < 100) begin tick(1); n++; end
        check("calib rise to soc release", 32'(n), 13);
        check("ready in run", 32'({ready, state}), 32'({1'b1, 3'd3}));
        check("retries in run", 32'(retries), 0);

        // Calibration loss in RUN
        calib = 1'b0;
        tick(3);
        check("lost pulse", 32'({lost, soc_arst, ddr_sys_rst}), 32'h7);
        check("lost retries", 32'(retries), 0);
        tick(1);
        check("lost one cycle", 32'(lost), 0);

        // Calibration never arrives
        start = 1'b1; tick(1); start = 1'b0;
        prev = ddr_sys_rst; falls = 0;
        for (int i = 0; i < 2000 && !error; i++) begin
            tick(1);
            if (prev && !ddr_sys_rst) falls++;
            prev = ddr_sys_rst;
        end
        check("ddr pulses before fail", 32'(falls), RETRY_EN ? 4 : 1);
        check("fail retries", 32'(retries), RETRY_EN ? 3 : 0);
        check("fail state", 32'({error, state}), 32'({1'b1, 3'd4}));

        // Restart from FAIL
        start = 1'b1; tick(1); start = 1'b0;
        check("restart state/retries/error", 32'({state, retries, error}), 0);
        calib = 1'b1;
        for (int i = 0; i < 300 && !ready; i++) tick(1);
        check("restart reaches run", 32'({ready, retries}), 32'h10);

        // Asynchronous reset mid WAIT_CAL
        calib = 1'b0;
        for (int i = 0; i < 100 && state != 3'd1; i++) tick(1);
        tick(37);
        check("in wait_cal before reset", 32'(state), 1);
        #2 arstn = 1'b0;
        #1;
        check("async reset outputs", 32'({state, ddr_sys_rst, soc_arst, ready, error, lost, retries}),
              32'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
        @(posedge clk); #1 arstn = 1'b1;
        pw = 0;
        for (int i = 0; i < 50 && ddr_sys_rst; i++) begin pw++; tick(1); end
        check("ddr pulse after reset release", 32'(pw), 4);

        // Calibration coincides with timeout
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 500 && !(state == 3'd1 && (!RETRY_EN || retries == 4'd1)); i++) tick(1);
        tick(97);
        calib = 1'b1;
        tick(3);
        check("cal wins over timeout", 32'({state, retries}), 32'({3'd2, RETRY_EN ? 4'd1 : 4'd0}));

        // Random soak
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) calib = ~calib;
            start = ($urandom_range(0, 299) == 0);
            if (arstn && $urandom_range(0, 999) == 0) arstn = 1'b0;
            else if (!arstn && $urandom_range(0, 2) == 0) arstn = 1'b1;
            tick(1);
        end
        start = 1'b0;
        arstn = 1'b1;
        tick(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iob_soc_versat_ddr_init_seq.md
IOB_SOC_VERSAT_DDR_INIT_SEQ -- requirements
Module: iob_soc_versat_ddr_init_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles ddr_sys_rst_o is held high per attempt (valid range 1..2^CNT_W-1).
REQ-002 SHALL have parameter CAL_TIMEOUT, default 2000000: cycles allowed for calibration per attempt.
REQ-003 SHALL have parameter HOLD_CYCLES, default 10: cycles soc_arst_o stays high after calibration is seen.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: extra attempts after the first timeout.
REQ-005 SHALL have parameter CNT_W, default 24: cycle-counter width; RETRY_W = 4, fixed.
REQ-006 clk_i  input  1  system clock, the single clock of the block.
REQ-007 arstn_i  input  1  reset, asynchronous and active-low.
REQ-008 calib_done_i  input  1  DDR controller init_calib_complete, asynchronous to clk_i.
REQ-009 start_i  input  1  single-cycle restart request.
REQ-010 ddr_sys_rst_o  output  1  active-high reset to DDR controller sys_rst.
REQ-011 soc_arst_o  output  1  active-high reset to the SoC core.
REQ-012 ready_o  output  1  high only in RUN.
REQ-013 error_o  output  1  high only in FAIL.
REQ-014 lost_o  output  1  one-cycle pulse on calibration loss during RUN.
REQ-015 retries_o  output  RETRY_W  attempts consumed in current sequence.
REQ-016 state_o  output  3  encoding: DDR_RST=0, WAIT_CAL=1, HOLD=2, RUN=3, FAIL=4.

Function
REQ-017 SHALL synchronise calib_done_i through two clk_i flops; all state decisions SHALL use the synchronised value (cal_s).
REQ-018 DDR_RST: ddr_sys_rst_o=1, soc_arst_o=1; counter counts from 0; at count RST_CYCLES-1, go to WAIT_CAL and clear counter.
REQ-019 WAIT_CAL: ddr_sys_rst_o=0, soc_arst_o=1; cal_s=1 -> HOLD (counter cleared); else at count CAL_TIMEOUT-1 -> timeout.
REQ-020 Timeout with retries_o < MAX_RETRIES SHALL increment retries_o and go to DDR_RST; otherwise SHALL go to FAIL.
REQ-021 If cal_s=1 and the timeout fires in the same cycle, calibration SHALL win (go to HOLD).
REQ-022 HOLD: soc_arst_o=1; cal_s=0 -> DDR_RST (no retry increment); else after HOLD_CYCLES cycles -> RUN.
REQ-023 RUN: soc_arst_o=0, ready_o=1; cal_s falling to 0 SHALL pulse lost_o for one cycle, clear retries_o, and go to DDR_RST with soc_arst_o=1 on the next cycle.
REQ-024 FAIL: ddr_sys_rst_o=0, soc_arst_o=1, error_o=1; stays until start_i or reset.
REQ-025 start_i in any state SHALL clear retries_o and counter and go to DDR_RST next cycle; start_i has priority over every other transition.
REQ-026 All outputs SHALL be registered; a state change is visible on outputs one cycle after the triggering condition.
REQ-027 Counter SHALL never wrap; it is cleared on every state entry.

Reset
REQ-028 arstn_i low SHALL immediately force state DDR_RST, counter=0, retries_o=0, sync flops=0, ddr_sys_rst_o=1, soc_arst_o=1, ready_o=0, error_o=0, lost_o=0.
REQ-029 Reset deassertion mid-sequence SHALL restart from DDR_RST with a full RST_CYCLES pulse.

Configuration
REQ-030 Macro IOB_SOC_VERSAT_DDR_INIT_RETRY_EN defined: retry behaviour per REQ-020.
REQ-031 Macro undefined: the first timeout SHALL go directly to FAIL, MAX_RETRIES ignored, retries_o tied to 0.

Verification
REQ-032 RST_CYCLES=4, calib_done_i rises 50 cycles after ddr_sys_rst_o falls -> ddr_sys_rst_o high exactly 4 cycles, RUN reached, soc_arst_o falls HOLD_CYCLES(10)+sync latency after rise, retries_o=0.
REQ-033 CAL_TIMEOUT=100, calib_done_i never rises, retry enabled -> 4 DDR_RST pulses, retries_o=3, then FAIL, error_o=1; macro off -> 1 pulse then FAIL.
REQ-034 In RUN drop calib_done_i -> lost_o one-cycle pulse, soc_arst_o=1 and ddr_sys_rst_o=1 next-next cycle, retries_o=0.
REQ-035 In FAIL pulse start_i -> state_o=0, retries_o=0, full new sequence reaching RUN when calib_done_i high.
REQ-036 Assert arstn_i low during WAIT_CAL at count 37 -> outputs take REQ-028 values without waiting for a clk_i edge; after release ddr_sys_rst_o high for RST_CYCLES.
REQ-037 calib_done_i rising on the same cycle as timeout (cal_s aligned to count CAL_TIMEOUT-1) -> HOLD entered, retries_o unchanged.
